// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate response checker.
package gate_chk_pkg;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  // Truth tables are indexed by {a,b}.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_chk_settle.sv
// Input-change detector and stability counter; strobes once a new {a,b} has held for SETTLE edges.
module gate_chk_settle
  import gate_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] ab,
  output logic       stable,
  output logic [1:0] prev_ab
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [1:0]    next_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SETTLE;
      cnt     <= '0;
      prev_ab <= 2'b00;
    end else if (clear) begin
      state   <= ST_SETTLE;
      cnt     <= '0;
      prev_ab <= 2'b00;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      prev_ab <= next_prev;
    end
  end

  // An input change always restarts settling, even on what would have been the check edge.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_prev  = prev_ab;
    if (ab != prev_ab) begin
      next_prev  = ab;
      next_cnt   = '0;
      next_state = ST_SETTLE;
    end else if (state == ST_SETTLE) begin
      if (cnt == LAST) begin
        next_state = ST_WAIT;
      end else begin
        next_cnt = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    stable = (state == ST_SETTLE) && (ab == prev_ab) && (cnt == LAST);
  end

endmodule

// File: rtl/gate_chk.sv
// Gate response checker: compares c against TRUTH once {a,b} has settled, counts failures and tracks coverage.
module gate_chk
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_NAND,
  parameter int         SETTLE = 2,
  parameter int         ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             mismatch,
  output logic [1:0]       err_vec,
  output logic             done,
  output logic             pass
);

  logic [1:0] ab;
  logic [1:0] prev_ab;
  logic       stable;
  logic       fail;

  assign ab = {a, b};

  gate_chk_settle #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .ab     (ab),
    .stable (stable),
    .prev_ab(prev_ab)
  );

  assign fail = stable && (c != TRUTH[prev_ab]);

  // Clear outranks a check landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      cov      <= 4'b0000;
      mismatch <= 1'b0;
      err_vec  <= 2'b00;
    end else if (clear) begin
      err_cnt  <= '0;
      cov      <= 4'b0000;
      mismatch <= 1'b0;
      err_vec  <= 2'b00;
    end else begin
      mismatch <= fail;
      if (stable) begin
        cov[prev_ab] <= 1'b1;
      end
      if (fail) begin
        err_vec <= prev_ab;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

  assign done = &cov;
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_gate_chk.sv
// Randomized and directed bench for gate_chk; three instances share stimulus and a hold-length reference model.
module tb_gate_chk;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] err0;
  logic [1:0] err1;
  logic [3:0] err2;
  logic [7:0] err_a [3];
  logic [3:0] cov_a [3];
  logic       mis_a [3];
  logic [1:0] vec_a [3];
  logic       done_a[3];
  logic       pass_a[3];

  assign err_a[0] = err0;
  assign err_a[1] = {6'b0, err1};
  assign err_a[2] = {4'b0, err2};

  gate_chk #(.TRUTH(TT_NAND), .SETTLE(2), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .a(a), .b(b), .c(c),
    .err_cnt(err0), .cov(cov_a[0]), .mismatch(mis_a[0]), .err_vec(vec_a[0]),
    .done(done_a[0]), .pass(pass_a[0]));

  gate_chk #(.TRUTH(TT_NAND), .SETTLE(2), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .a(a), .b(b), .c(c),
    .err_cnt(err1), .cov(cov_a[1]), .mismatch(mis_a[1]), .err_vec(vec_a[1]),
    .done(done_a[1]), .pass(pass_a[1]));

  gate_chk #(.TRUTH(TT_XOR), .SETTLE(3), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .a(a), .b(b), .c(c),
    .err_cnt(err2), .cov(cov_a[2]), .mismatch(mis_a[2]), .err_vec(vec_a[2]),
    .done(done_a[2]), .pass(pass_a[2]));

  int checks = 0;
  int errors = 0;

  // Reference model: a vector is checked when it has been presented for exactly SETTLE+1 edges.
  int         settle_m[3] = '{2, 2, 3};
  logic [3:0] truth_m [3] = '{TT_NAND, TT_NAND, TT_XOR};
  int         errmax  [3] = '{255, 3, 15};
  logic [1:0] last_ab;
  int         run;
  int         exp_err[3];
  logic [3:0] exp_cov[3];
  logic [1:0] exp_vec[3];
  logic       exp_mis[3];
  int         obs_pulses[3];
  int         exp_pulses[3];

  function automatic logic nand_of(input logic [1:0] v);
    return !(v[1] && v[0]);
  endfunction

  task automatic model_reset();
    last_ab = 2'b00;
    run = 1;
    for (int i = 0; i < 3; i++) begin
      exp_err[i] = 0;
      exp_cov[i] = 4'b0000;
      exp_vec[i] = 2'b00;
      exp_mis[i] = 1'b0;
    end
  endtask

  task automatic zero_pulses();
    for (int i = 0; i < 3; i++) begin
      obs_pulses[i] = 0;
      exp_pulses[i] = 0;
    end
  endtask

  task automatic step(input logic [1:0] ab, input logic cv, input logic clr);
    {a, b} = ab;
    c = cv;
    clear = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      if (ab != last_ab) begin
        last_ab = ab;
        run = 1;
      end else begin
        run++;
      end
      for (int i = 0; i < 3; i++) begin
        exp_mis[i] = 1'b0;
        if (run == settle_m[i] + 1) begin
          exp_cov[i][ab] = 1'b1;
          if (cv != truth_m[i][ab]) begin
            exp_mis[i] = 1'b1;
            exp_vec[i] = ab;
            if (exp_err[i] < errmax[i]) exp_err[i]++;
          end
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs_pulses[i] += int'(mis_a[i]);
      exp_pulses[i] += int'(exp_mis[i]);
    end
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {a, b} = 2'b00;
    c = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({err_a[i], cov_a[i], mis_a[i], vec_a[i], done_a[i], pass_a[i]} !== 17'h0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d got err=%0h cov=%b mis=%b vec=%b done=%b pass=%b required all 0",
                 i, err_a[i], cov_a[i], mis_a[i], vec_a[i], done_a[i], pass_a[i]);
      end
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_correct_gate();
    zero_pulses();
    for (int v = 0; v < 4; v++)
      repeat (4) step(2'(v), nand_of(2'(v)), 1'b0);
    checks++;
    if (cov_a[0] !== 4'b1111 || err_a[0] !== 8'd0 || done_a[0] !== 1'b1 || pass_a[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL correct_gate got cov=%b err=%0d done=%b pass=%b required 1111 0 1 1",
               cov_a[0], err_a[0], done_a[0], pass_a[0]);
    end
    checks++;
    if (obs_pulses[0] !== 0) begin
      errors++;
      $display("[TB] FAIL correct_gate_pulses got %0d required 0", obs_pulses[0]);
    end
    checks++;
    if (err_a[2] !== 8'(exp_err[2]) || cov_a[2] !== exp_cov[2] || vec_a[2] !== exp_vec[2]) begin
      errors++;
      $display("[TB] FAIL correct_gate_xor got err=%0d cov=%b vec=%b required err=%0d cov=%b vec=%b",
               err_a[2], cov_a[2], vec_a[2], exp_err[2], exp_cov[2], exp_vec[2]);
    end
  endtask

  task automatic test_stuck_one();
    step(2'b00, 1'b1, 1'b1);
    zero_pulses();
    for (int v = 0; v < 4; v++)
      repeat (4) step(2'(v), 1'b1, 1'b0);
    checks++;
    if (err_a[0] !== 8'd1 || vec_a[0] !== 2'b11 || done_a[0] !== 1'b1 || pass_a[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stuck_one got err=%0d vec=%b done=%b pass=%b required 1 11 1 0",
               err_a[0], vec_a[0], done_a[0], pass_a[0]);
    end
    checks++;
    if (obs_pulses[0] !== 1) begin
      errors++;
      $display("[TB] FAIL stuck_one_pulses got %0d required 1", obs_pulses[0]);
    end
  endtask

  task automatic test_glitch();
    step(2'b00, 1'b1, 1'b1);
    repeat (4) step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    repeat (4) step(2'b00, 1'b1, 1'b0);
    checks++;
    if (cov_a[0] !== 4'b0001 || err_a[0] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL glitch got cov=%b err=%0d required 0001 0", cov_a[0], err_a[0]);
    end
    // The XOR instance fails every 00 check, so two errors prove 00 was checked again.
    checks++;
    if (err_a[2] !== 8'd2 || cov_a[2] !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL glitch_recheck got err=%0d cov=%b required 2 0001", err_a[2], cov_a[2]);
    end
  endtask

  task automatic test_saturation();
    step(2'b00, 1'b1, 1'b1);
    zero_pulses();
    repeat (5) begin
      repeat (3) step(2'b11, 1'b1, 1'b0);
      repeat (3) step(2'b10, 1'b1, 1'b0);
    end
    checks++;
    if (err_a[1] !== 8'd3 || obs_pulses[1] !== 5) begin
      errors++;
      $display("[TB] FAIL saturation got err=%0d pulses=%0d required 3 5", err_a[1], obs_pulses[1]);
    end
    checks++;
    if (err_a[0] !== 8'd5 || vec_a[1] !== 2'b11) begin
      errors++;
      $display("[TB] FAIL saturation_wide got err=%0d vec=%b required 5 11", err_a[0], vec_a[1]);
    end
  endtask

  task automatic test_reset_mid();
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({err_a[i], cov_a[i], mis_a[i], vec_a[i], done_a[i], pass_a[i]} !== 17'h0) begin
        errors++;
        $display("[TB] FAIL reset_mid dut%0d got err=%0h cov=%b mis=%b required all 0",
                 i, err_a[i], cov_a[i], mis_a[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (mis_a[0] !== 1'b0 || err_a[0] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_pending got mis=%b err=%0d required 0 0", mis_a[0], err_a[0]);
    end
    model_reset();
    {a, b} = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_clear_vs_check();
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    checks++;
    if (err_a[0] !== 8'd0 || cov_a[0] !== 4'b0000 || mis_a[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_vs_check got err=%0d cov=%b mis=%b required 0 0000 0",
               err_a[0], cov_a[0], mis_a[0]);
    end
  endtask

  task automatic test_random();
    int steps = 0;
    while (steps < 400) begin
      logic [1:0] v;
      int n;
      v = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 5);
      repeat (n) begin
        logic cv, clr;
        cv = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : nand_of(v);
        clr = ($urandom_range(0, 59) == 0);
        step(v, cv, clr);
        steps++;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (err_a[i] !== 8'(exp_err[i]) || cov_a[i] !== exp_cov[i] || mis_a[i] !== exp_mis[i] ||
              vec_a[i] !== exp_vec[i] || done_a[i] !== (&exp_cov[i]) ||
              pass_a[i] !== ((&exp_cov[i]) && exp_err[i] == 0)) begin
            errors++;
            $display("[TB] FAIL random dut%0d step%0d got err=%0d cov=%b mis=%b vec=%b done=%b pass=%b required err=%0d cov=%b mis=%b vec=%b",
                     i, steps, err_a[i], cov_a[i], mis_a[i], vec_a[i], done_a[i], pass_a[i],
                     exp_err[i], exp_cov[i], exp_mis[i], exp_vec[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_gate();
    test_stuck_one();
    test_glitch();
    test_saturation();
    test_reset_mid();
    test_clear_vs_check();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
